// File: rtl/burst_code_pkg.sv
// burst_code_pkg: shared constants and deframer FSM state type for the (44,32) burst-error-correcting code path
package burst_code_pkg;
  localparam int CW_LEN = 44;
  localparam int MSG_LEN = 32;
  localparam int BURST_LEN = 5;
  localparam int CNT_W = $clog2(CW_LEN);
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/burst_rx_deframer_burst_inject.sv
// burst_inject: combinational burst mask builder; in inj_pos/inj_pat, out mask with inj_pat[k] at bit inj_pos+k, bits past CW_LEN-1 clipped (no wrap)
module burst_inject #(
  parameter int CW_LEN = burst_code_pkg::CW_LEN,
  parameter int BURST_LEN = burst_code_pkg::BURST_LEN
) (
  input logic [$clog2(CW_LEN)-1:0] inj_pos,
  input logic [0:BURST_LEN-1] inj_pat,
  output logic [0:CW_LEN-1] mask
);
  always_comb mask = CW_LEN'(({inj_pat, {CW_LEN{1'b0}}} >> inj_pos) >> BURST_LEN);
endmodule

// File: rtl/burst_rx_deframer.sv
// burst_rx_deframer: sof-framed serial-to-codeword deframer with one-deep holding register; in clk/rst/ser_bit/ser_valid/ser_sof/cw_ready, out cw_data/cw_valid/sync_err/overrun/frame_cnt; BURST_INJECT_EN adds inj_en/inj_pos/inj_pat burst injection at load
module burst_rx_deframer #(
  parameter int CW_LEN = burst_code_pkg::CW_LEN,
  parameter int BURST_LEN = burst_code_pkg::BURST_LEN,
  parameter int FCNT_W = 16
) (
  input logic clk,
  input logic rst,
`ifdef BURST_INJECT_EN
  input logic inj_en,
  input logic [$clog2(CW_LEN)-1:0] inj_pos,
  input logic [0:BURST_LEN-1] inj_pat,
`endif
  input logic ser_bit,
  input logic ser_valid,
  input logic ser_sof,
  output logic [0:CW_LEN-1] cw_data,
  output logic cw_valid,
  input logic cw_ready,
  output logic sync_err,
  output logic overrun,
  output logic [FCNT_W-1:0] frame_cnt
);
  import burst_code_pkg::*;
  localparam int CNT_BITS = $clog2(CW_LEN);
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(CW_LEN - 1);
  if (CW_LEN < 2 || BURST_LEN < 1) begin : g_bad_cfg
    $error("burst_rx_deframer: CW_LEN must be >= 2 and BURST_LEN >= 1");
  end
  state_t state, state_nxt;
  logic [CNT_BITS-1:0] cnt;
  logic [0:CW_LEN-1] sr, full, load_word;
  logic restart, take, complete, hold_free, load;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_comb
    state_nxt = (ser_valid & ser_sof) ? SHIFT
              : (state == SHIFT && ser_valid && cnt == LAST) ? IDLE : state;
  always_comb begin
    restart = ser_valid & ser_sof;
    take = ser_valid & !ser_sof & (state == SHIFT);
    complete = take & (cnt == LAST);
    hold_free = !cw_valid | cw_ready;
    load = complete & hold_free;
    full = sr;
    full[CW_LEN-1] = ser_bit;
  end
`ifdef BURST_INJECT_EN
  logic [0:CW_LEN-1] mask;
  burst_inject #(.CW_LEN(CW_LEN), .BURST_LEN(BURST_LEN)) u_inject (
    .inj_pos(inj_pos),
    .inj_pat(inj_pat),
    .mask(mask)
  );
  assign load_word = inj_en ? full ^ mask : full;
`else
  assign load_word = full;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      sr <= '0;
      cw_data <= '0;
      cw_valid <= 1'b0;
      sync_err <= 1'b0;
      overrun <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (restart) begin
        sr[0] <= ser_bit;
        cnt <= CNT_BITS'(1);
      end else if (take) begin
        sr[cnt] <= ser_bit;
        cnt <= complete ? '0 : cnt + CNT_BITS'(1);
      end
      if (load) begin
        cw_data <= load_word;
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
      cw_valid <= load | (cw_valid & !cw_ready);
      sync_err <= restart & (state == SHIFT);
      overrun <= complete & !hold_free;
    end
endmodule

// File: tb/tb_burst_rx_deframer.sv
// tb_burst_rx_deframer: directed and randomized self-checking bench for burst_rx_deframer against a frame-level reference model
module tb_burst_rx_deframer;
  localparam int CW = 44;
  localparam int BL = 5;
  logic clk = 0, rst = 1, ser_bit = 0, ser_valid = 0, ser_sof = 0, cw_ready = 0;
  logic [0:CW-1] cw_data;
  logic cw_valid, sync_err, overrun;
  logic [15:0] frame_cnt;
`ifdef BURST_INJECT_EN
  logic inj_en = 0;
  logic [5:0] inj_pos = 0;
  logic [0:BL-1] inj_pat = 0;
`endif
  int n_cmp = 0, n_bad = 0;
  int m_pos = 0, m_cnt = 0, ovr_seen = 0;
  bit m_valid = 0, m_sync = 0, m_ovr = 0, seen_valid = 0;
  logic [0:CW-1] m_bits, m_data = '0;
  always #5 clk = ~clk;
  burst_rx_deframer dut (
    .clk(clk),
    .rst(rst),
`ifdef BURST_INJECT_EN
    .inj_en(inj_en),
    .inj_pos(inj_pos),
    .inj_pat(inj_pat),
`endif
    .ser_bit(ser_bit),
    .ser_valid(ser_valid),
    .ser_sof(ser_sof),
    .cw_data(cw_data),
    .cw_valid(cw_valid),
    .cw_ready(cw_ready),
    .sync_err(sync_err),
    .overrun(overrun),
    .frame_cnt(frame_cnt)
  );
  task automatic mdl(input logic v, input logic s, input logic b);
    bit done;
    done = 0;
    m_sync = 0;
    m_ovr = 0;
    if (rst) begin
      m_pos = 0;
      m_cnt = 0;
      m_valid = 0;
      m_data = '0;
      return;
    end
    if (v && s) begin
      m_sync = m_pos > 0;
      m_pos = 1;
      m_bits[0] = b;
    end else if (v && m_pos > 0) begin
      m_bits[m_pos] = b;
      m_pos++;
      done = m_pos == CW;
    end
    if (m_valid && cw_ready) m_valid = 0;
    if (done) begin
      m_pos = 0;
      if (m_valid) m_ovr = 1;
      else begin
        m_valid = 1;
        m_data = m_bits;
        m_cnt++;
`ifdef BURST_INJECT_EN
        if (inj_en)
          for (int k = 0; k < BL; k++)
            if (int'(inj_pos) + k < CW) m_data[int'(inj_pos) + k] ^= inj_pat[k];
`endif
      end
    end
  endtask
  task automatic step(input logic v, input logic s, input logic b);
    ser_valid = v;
    ser_sof = s;
    ser_bit = b;
    @(posedge clk);
    #1;
    mdl(v, s, b);
    seen_valid |= cw_valid;
    ovr_seen += int'(overrun);
  endtask
  task automatic send(input logic [CW-1:0] w, input int lo, input int hi, input bit gap);
    for (int i = lo; i <= hi; i++) begin
      if (gap) step(0, 1'($urandom), 1'($urandom));
      step(1, i == 0, w[CW-1-i]);
    end
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) step(0, 0, 0);
    n_cmp++; if (cw_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", cw_valid); end
    n_cmp++; if (cw_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", cw_data); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
    n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL reset_sync: got %b want 0", sync_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    rst = 0;
  endtask
  task automatic test_contiguous;
    logic [CW-1:0] w;
    w = 44'hF0F0F0F0F0F;
    cw_ready = 1;
    send(w, 0, 42, 0);
    n_cmp++; if (cw_valid !== 1'b0) begin n_bad++; $display("FAIL contig_early: got %b want 0", cw_valid); end
    send(w, 43, 43, 0);
    n_cmp++; if (cw_valid !== 1'b1) begin n_bad++; $display("FAIL contig_valid: got %b want 1", cw_valid); end
    n_cmp++; if (cw_data !== w) begin n_bad++; $display("FAIL contig_data: got %h want %h", cw_data, w); end
    n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL contig_cnt: got %0d want 1", frame_cnt); end
    step(0, 0, 0);
    n_cmp++; if (cw_valid !== 1'b0) begin n_bad++; $display("FAIL contig_drain: got %b want 0", cw_valid); end
  endtask
  task automatic test_gapped;
    logic [CW-1:0] w;
    w = 44'hF0F0F0F0F0F;
    send(w, 0, 42, 1);
    step(0, 0, 0);
    n_cmp++; if (cw_valid !== 1'b0) begin n_bad++; $display("FAIL gap_early: got %b want 0", cw_valid); end
    step(1, 0, w[0]);
    n_cmp++; if (cw_valid !== 1'b1) begin n_bad++; $display("FAIL gap_valid: got %b want 1", cw_valid); end
    n_cmp++; if (cw_data !== w) begin n_bad++; $display("FAIL gap_data: got %h want %h", cw_data, w); end
    n_cmp++; if (frame_cnt !== 16'd2) begin n_bad++; $display("FAIL gap_cnt: got %0d want 2", frame_cnt); end
    step(0, 0, 0);
  endtask
  task automatic test_overrun;
    cw_ready = 0;
    send(44'h00000000001, 0, 43, 0);
    n_cmp++; if (cw_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_first_valid: got %b want 1", cw_valid); end
    ovr_seen = 0;
    send(44'h80000000000, 0, 43, 0);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
    n_cmp++; if (cw_data !== 44'h00000000001) begin n_bad++; $display("FAIL ovr_data: got %h want 00000000001", cw_data); end
    n_cmp++; if (frame_cnt !== 16'd3) begin n_bad++; $display("FAIL ovr_cnt: got %0d want 3", frame_cnt); end
    step(0, 0, 0);
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_width: got %b want 0", overrun); end
    n_cmp++; if (ovr_seen !== 1) begin n_bad++; $display("FAIL ovr_count: got %0d want 1", ovr_seen); end
    cw_ready = 1;
    step(0, 0, 0);
    n_cmp++; if (cw_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_drain: got %b want 0", cw_valid); end
  endtask
  task automatic test_sync_err;
    logic [CW-1:0] a, b;
    a = 44'({$urandom, $urandom});
    b = 44'({$urandom, $urandom});
    cw_ready = 1;
    seen_valid = 0;
    send(a, 0, 19, 0);
    send(b, 0, 0, 0);
    n_cmp++; if (sync_err !== 1'b1) begin n_bad++; $display("FAIL sync_pulse: got %b want 1", sync_err); end
    send(b, 1, 1, 0);
    n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL sync_width: got %b want 0", sync_err); end
    send(b, 2, 42, 0);
    n_cmp++; if (seen_valid !== 1'b0) begin n_bad++; $display("FAIL sync_partial_out: got %b want 0", seen_valid); end
    send(b, 43, 43, 0);
    n_cmp++; if (cw_data !== b) begin n_bad++; $display("FAIL sync_data: got %h want %h", cw_data, b); end
    n_cmp++; if (frame_cnt !== 16'd4) begin n_bad++; $display("FAIL sync_cnt: got %0d want 4", frame_cnt); end
    step(0, 0, 0);
  endtask
  task automatic test_back_to_back;
    logic [CW-1:0] x, y;
    x = 44'({$urandom, $urandom});
    y = 44'({$urandom, $urandom});
    cw_ready = 0;
    send(x, 0, 43, 0);
    n_cmp++; if (cw_data !== x) begin n_bad++; $display("FAIL b2b_first: got %h want %h", cw_data, x); end
    send(y, 0, 42, 0);
    cw_ready = 1;
    send(y, 43, 43, 0);
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_ovr: got %b want 0", overrun); end
    n_cmp++; if (cw_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1", cw_valid); end
    n_cmp++; if (cw_data !== y) begin n_bad++; $display("FAIL b2b_data: got %h want %h", cw_data, y); end
    n_cmp++; if (frame_cnt !== 16'd6) begin n_bad++; $display("FAIL b2b_cnt: got %0d want 6", frame_cnt); end
    step(0, 0, 0);
    n_cmp++; if (cw_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", cw_valid); end
  endtask
  task automatic test_mid_reset;
    logic [CW-1:0] x, z;
    x = 44'({$urandom, $urandom});
    z = 44'({$urandom, $urandom});
    cw_ready = 0;
    send(x, 0, 43, 0);
    send(z, 0, 29, 0);
    rst = 1;
    step(1, 0, z[CW-31]);
    rst = 0;
    n_cmp++; if (cw_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid: got %b want 0", cw_valid); end
    n_cmp++; if (cw_data !== '0) begin n_bad++; $display("FAIL mrst_data: got %h want 0", cw_data); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL mrst_cnt: got %0d want 0", frame_cnt); end
    seen_valid = 0;
    send(z, 31, 43, 0);
    n_cmp++; if (seen_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_tail: got %b want 0", seen_valid); end
    cw_ready = 1;
    send(44'hFFFFFFFFFFF, 0, 43, 0);
    n_cmp++; if (cw_data !== 44'hFFFFFFFFFFF) begin n_bad++; $display("FAIL mrst_next_data: got %h want FFFFFFFFFFF", cw_data); end
    n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL mrst_next_cnt: got %0d want 1", frame_cnt); end
    step(0, 0, 0);
  endtask
`ifdef BURST_INJECT_EN
  task automatic test_inject;
    logic [CW-1:0] w;
    cw_ready = 1;
    inj_en = 1;
    inj_pos = 6'd40;
    inj_pat = 5'b11111;
    send('0, 0, 43, 0);
    n_cmp++; if (cw_data !== 44'h0000000000F) begin n_bad++; $display("FAIL inj_clip: got %h want 0000000000F", cw_data); end
    for (int r = 0; r < 8; r++) begin
      w = 44'({$urandom, $urandom});
      inj_pos = 6'($urandom_range(0, CW - 1));
      inj_pat = 5'($urandom);
      send(w, 0, 43, 0);
      n_cmp++; if (cw_data !== m_data) begin n_bad++; $display("FAIL inj_rand: got %h want %h", cw_data, m_data); end
    end
    w = 44'({$urandom, $urandom});
    inj_pat = 5'b10101;
    send(w, 0, 42, 0);
    inj_en = 0;
    send(w, 43, 43, 0);
    n_cmp++; if (cw_data !== w) begin n_bad++; $display("FAIL inj_sample: got %h want %h", cw_data, w); end
    step(0, 0, 0);
  endtask
`endif
  task automatic test_random;
    logic v, s;
    for (int c = 0; c < 3000; c++) begin
      cw_ready = 1'($urandom);
      rst = ($urandom % 800) == 0;
`ifdef BURST_INJECT_EN
      inj_en = 1'($urandom);
      inj_pos = 6'($urandom_range(0, CW - 1));
      inj_pat = 5'($urandom);
`endif
      v = ($urandom % 4) != 0;
      s = !v ? 1'($urandom) : (m_pos == 0 ? 1'($urandom) : ($urandom % 64) == 0);
      step(v, s, 1'($urandom));
      n_cmp++; if (cw_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid@%0d: got %b want %b", c, cw_valid, m_valid); end
      n_cmp++; if (cw_data !== m_data) begin n_bad++; $display("FAIL rnd_data@%0d: got %h want %h", c, cw_data, m_data); end
      n_cmp++; if (sync_err !== m_sync) begin n_bad++; $display("FAIL rnd_sync@%0d: got %b want %b", c, sync_err, m_sync); end
      n_cmp++; if (overrun !== m_ovr) begin n_bad++; $display("FAIL rnd_ovr@%0d: got %b want %b", c, overrun, m_ovr); end
      n_cmp++; if (frame_cnt !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", c, frame_cnt, 16'(m_cnt)); end
    end
    rst = 0;
  endtask
  initial begin
    test_reset;
    test_contiguous;
    test_gapped;
    test_overrun;
    test_sync_err;
    test_back_to_back;
    test_mid_reset;
`ifdef BURST_INJECT_EN
    test_inject;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
